fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Controls the synchronous-read instruction memory (10-bit word address, 32-bit word, one-cycle read latency) and delivers instructions to decode.
- Holds the program counter and starts a run on command, stopping after a programmable end address.
- Supports branch/jump redirects; a 2-entry output buffer absorbs the read latency so decode can stall without losing or duplicating instructions.

Parameters:
- ADDR_W, 10, instruction word address width.
- DATA_W, 32, instruction width.
- RESET_PC, 0, PC and imem_addr value after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run. Honoured only in IDLE.
- start_pc  in  ADDR_W  first fetch address; sampled with start.
- end_pc  in  ADDR_W  last fetch address of the run; sampled with start.
- redirect  in  1  branch/jump taken; honoured in RUN and DRAIN.
- redirect_pc  in  ADDR_W  new fetch address; sampled with redirect.
- imem_addr  out  ADDR_W  memory address, driven directly from the PC register.
- imem_data  in  DATA_W  memory read data; valid one cycle after the address is sampled.
- out_valid  out  1  buffer head holds an instruction.
- out_ready  in  1  decode accepts the head; pop = out_valid & out_ready.
- out_instr  out  DATA_W  head instruction.
- out_pc  out  ADDR_W  address of the head instruction.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a run completes.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, buffer count=0, inflight=0, kill=0. Outputs: out_valid=0, busy=0, done=0, imem_addr=RESET_PC. out_instr and out_pc are 0.
- States and transitions:
  - IDLE: on start, pc<=start_pc, end_q<=end_pc, go to RUN.
  - RUN: issue requests. Issuing the address equal to end_q moves to DRAIN.
  - DRAIN: no issues. When inflight=0 and count=0, go to DONE.
  - DONE: assert done for exactly one cycle, then return to IDLE.
- Issue condition: state==RUN, no redirect this cycle, and count + inflight - pop < 2.
- On issue: the memory samples imem_addr(=pc) at that edge; inflight<=1 and ifl_pc<=pc; pc<=pc+1, wrapping 1023->0.
- When no issue occurs: inflight<=0. Data returned from a killed request is ignored.
- Return cycle: if inflight=1 and kill=0, push {imem_data, ifl_pc} into the buffer at the edge. Push and pop in the same cycle are legal.
- Buffer: 2-entry FIFO with registered storage. The head drives out_instr and out_pc; out_valid = (count != 0). Overflow cannot occur because of the issue condition.
- Full throughput: with out_ready held high, one instruction per cycle after 2 cycles of initial latency.
- Redirect, in RUN or DRAIN:
  - A pop in the same cycle completes normally; all remaining buffer entries are flushed (count<=0).
  - Any outstanding request is killed: kill<=inflight, so its data is dropped next cycle.
  - pc<=redirect_pc, state<=RUN, no issue in that cycle. end_q is unchanged.
  - A redirect in IDLE or DONE is ignored. start outside IDLE is ignored.
- start_pc==end_pc: exactly one instruction is issued, then DRAIN.
- end_q < start_pc: the PC wraps through 1023 and stops at end_q.
- Reset asserted mid-run: immediate return to reset values. No done pulse; pending memory data is discarded.

Test Plan:
- Basic run: start with start_pc=1, end_pc=4, out_ready=1 -> out_pc sequence 1,2,3,4 on consecutive cycles, first out_valid 2 cycles after start. done pulses once after pc 4 is accepted, then busy=0.
- Stall: same run with out_ready=0 for 5 cycles after the first valid -> imem_addr stops advancing once 2 entries are held. out_pc 1 holds stable; after release, 1,2,3,4 are delivered with no loss or duplication.
- Redirect: run 0..20 with redirect at the cycle out_pc=3 is popped, redirect_pc=10 -> accepted stream is 0,1,2,3,10,11,...,20. Data for addresses 4 and 5 is never presented.
- Redirect in DRAIN: end_pc=5 with redirect_pc=2 while draining -> fetching resumes at 2 and ends again after 5. There is one done pulse, at the end.
- Wrap and single-word runs: start_pc=1022, end_pc=1 -> out_pc 1022,1023,0,1. start_pc=end_pc=7 -> exactly one instruction delivered.
- Reset mid-run: rst_n low for 1 cycle at instruction 3 -> out_valid=0, busy=0, imem_addr=0 immediately, no done pulse. A new start runs normally.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer with 2-entry output buffer
module fetch_sequencer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc,
  input  logic [ADDR_W-1:0] end_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, end_q, ifl_pc;
  logic                inflight, kill;
  logic [DATA_W-1:0]   buf_instr [2];
  logic [ADDR_W-1:0]   buf_pc    [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count;

  logic                pop, push, redir, issue;
  logic [2:0]          occupancy;
  logic [1:0]          count_d;

  assign pop       = (count != 2'd0) && out_ready;
  assign redir     = redirect && ((state_q == S_RUN) || (state_q == S_DRAIN));
  assign occupancy = {1'b0, count} + {2'b00, inflight};
  // Count the slot freed by this cycle's pop so a full buffer drained at rate keeps streaming.
  assign issue     = (state_q == S_RUN) && !redirect &&
                     (occupancy < (3'd2 + {2'b00, pop}));
  assign push      = inflight && !kill && !redir;

  always_comb begin
    count_d = count;
    case ({push, pop})
      2'b10:   count_d = count + 2'd1;
      2'b01:   count_d = count - 2'd1;
      default: count_d = count;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (redir)                        state_d = S_RUN;
        else if (issue && pc_q == end_q)  state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (redir)                               state_d = S_RUN;
        else if (!inflight && count == 2'd0)     state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      end_q    <= RESET_PC;
      inflight <= 1'b0;
      kill     <= 1'b0;
      ifl_pc   <= '0;
    end else begin
      state_q  <= state_d;
      inflight <= issue;
      kill     <= redir && inflight;
      if (issue) ifl_pc <= pc_q;
      if (state_q == S_IDLE && start) begin
        pc_q  <= start_pc;
        end_q <= end_pc;
      end else if (redir) begin
        pc_q <= redirect_pc;
      end else if (issue) begin
        pc_q <= pc_q + ADDR_W'(1);
      end
    end
  end

  // Redirect flushes whatever is still queued; a same-cycle pop has already been taken by decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_instr[0] <= '0;
      buf_instr[1] <= '0;
      buf_pc[0]    <= '0;
      buf_pc[1]    <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
    end else if (redir) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        buf_instr[wr_ptr] <= imem_data;
        buf_pc[wr_ptr]    <= ifl_pc;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_d;
    end
  end

  assign imem_addr = pc_q;
  assign out_valid = (count != 2'd0);
  assign out_instr = buf_instr[rd_ptr];
  assign out_pc    = buf_pc[rd_ptr];
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [AW-1:0] end_pc = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          busy;
  logic          done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(AW), .DATA_W(DW), .RESET_PC('0)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .end_pc(end_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .imem_addr(imem_addr),
    .imem_data(imem_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .busy(busy), .done(done)
  );

  function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
    return ({a, 22'h0} ^ (32'h9E37_79B1 * {22'b0, a})) ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) imem_data <= word_of(imem_addr);
  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: accepted stream walks from start upward (mod 1024) to end; a redirect restarts it at redirect_pc.
  task automatic run(input logic [AW-1:0] s, input logic [AW-1:0] e, input int ready_pct,
                     input int n_rand, input int redir_at, input logic [AW-1:0] redir_to,
                     input int stall);
    logic [AW-1:0] exp_next = s;
    bit remaining = 1'b1;
    bit redirected = 1'b0;
    bit used_at = 1'b0;
    bit full = (ready_pct == 100) && (stall == 0);
    int cyc = 0;
    int first = -1;
    int redirs = 0;
    int stall_left = stall;
    int d0 = done_cnt;
    start = 1'b1; start_pc = s; end_pc = e;
    tick();
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    while (remaining && cyc < 3000) begin
      bit pop;
      redirect = 1'b0;
      if (cyc == 3) begin
        start = 1'b1; start_pc = s ^ 10'h155; end_pc = s ^ 10'h0AA;
      end else begin
        start = 1'b0;
      end
      if (out_valid && first < 0) begin
        first = cyc;
        if (full && n_rand == 0) chk("first_valid_latency", 32'(cyc), 32'd2);
      end
      if (full && first >= 0 && !redirected) chk("stream_gap", 32'(out_valid), 32'd1);
      if (first >= 0 && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
        chk("stall_head_pc", 32'(out_pc), 32'(s));
        chk("stall_imem_addr", 32'(imem_addr), 32'(AW'(s + AW'(2))));
      end else begin
        out_ready = ($urandom_range(1, 100) <= ready_pct);
      end
      pop = out_valid && out_ready;
      if (redir_at >= 0 && !used_at && pop && out_pc == AW'(redir_at)) begin
        redirect = 1'b1; redirect_pc = redir_to; used_at = 1'b1;
      end else if (redirs < n_rand && $urandom_range(0, 7) == 0) begin
        redirect = 1'b1; redirect_pc = e - AW'($urandom_range(0, 5)); redirs++;
      end
      if (pop) begin
        chk("out_pc", 32'(out_pc), 32'(exp_next));
        chk("out_instr", out_instr, word_of(out_pc));
        if (exp_next == e) remaining = 1'b0;
        else exp_next = exp_next + AW'(1);
      end
      if (redirect) begin
        exp_next = redirect_pc;
        remaining = 1'b1;
        redirected = 1'b1;
      end
      tick();
      cyc++;
    end
    if (remaining) chk("run_timeout", 32'd0, 32'd1);
    redirect = 1'b0; start = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && busy; i++) tick();
    chk("busy_end", 32'(busy), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("empty_end", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int d0;
    logic [AW-1:0] hold;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    rst_n = 1'b1;
    tick();

    redirect = 1'b1; redirect_pc = 10'd50;
    tick();
    redirect = 1'b0;
    chk("idle_redirect_busy", 32'(busy), 32'd0);
    chk("idle_redirect_addr", 32'(imem_addr), 32'd0);

    run(10'd1, 10'd4, 100, 0, -1, '0, 0);
    run(10'd1, 10'd4, 100, 0, -1, '0, 5);
    run(10'd0, 10'd20, 100, 0, 3, 10'd10, 0);
    run(10'd0, 10'd5, 100, 0, 4, 10'd2, 0);
    run(10'd1022, 10'd1, 100, 0, -1, '0, 0);
    run(10'd7, 10'd7, 100, 0, -1, '0, 0);

    out_ready = 1'b1; start = 1'b1; start_pc = 10'd0; end_pc = 10'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !(out_valid && out_pc == 10'd3); i++) tick();
    chk("reached_pc3", 32'(out_pc), 32'd3);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_addr", 32'(imem_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    hold = imem_addr;
    for (int i = 0; i < 5; i++) tick();
    chk("postrst_done", 32'(done_cnt - d0), 32'd0);
    chk("postrst_busy", 32'(busy), 32'd0);
    chk("postrst_addr", 32'(imem_addr), 32'(hold));

    run(10'd2, 10'd9, 100, 0, -1, '0, 0);

    for (int r = 0; r < 14; r++) begin
      logic [AW-1:0] s;
      s = AW'($urandom_range(0, 1023));
      run(s, s + AW'($urandom_range(0, 12)), $urandom_range(30, 95), 2, -1, '0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
